// File: rtl/param_datapath.sv
// Parameterised LC-3 style datapath: shared bus, 8-entry register file,
// ALU, address adder, architectural registers and a memory handshake FSM
// with a bounded wait and a sticky timeout flag.
module param_datapath #(
  parameter int unsigned      WIDTH       = 16,
  parameter logic [WIDTH-1:0] RESET_PC    = '0,
  parameter int unsigned      MEM_TIMEOUT = 15
) (
  input  logic             Clk,
  input  logic             Reset_al,
  input  logic [6:0]       ld,
  input  logic [3:0]       gate,
  input  logic [1:0]       pcmux,
  input  logic             addr1mux,
  input  logic [1:0]       addr2mux,
  input  logic [1:0]       aluk,
  input  logic             sr1mux,
  input  logic             drmux,
  input  logic             mem_start,
  input  logic             mem_we,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_wr,
  output logic             mem_busy,
  output logic             mem_done,
  output logic             mem_err,
  output logic [WIDTH-1:0] IR,
  output logic [WIDTH-1:0] PC,
  output logic [WIDTH-1:0] MAR,
  output logic [WIDTH-1:0] MDR,
  output logic [2:0]       nzp,
  output logic             BEN,
  output logic             bus_err
);

  localparam int unsigned LD_PC  = 6;
  localparam int unsigned LD_IR  = 5;
  localparam int unsigned LD_MAR = 4;
  localparam int unsigned LD_MDR = 3;
  localparam int unsigned LD_REG = 2;
  localparam int unsigned LD_CC  = 1;
  localparam int unsigned LD_BEN = 0;

  localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {
    MEM_IDLE,
    MEM_WAIT,
    MEM_DONE
  } mem_state_e;

  mem_state_e       state_q;
  logic [7:0]       cnt_q;
  logic             mem_wr_q;
  logic             mem_req_q;
  logic             mem_done_q;
  logic             mem_err_q;

  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pc_d;
  logic [WIDTH-1:0] ir_q;
  logic [WIDTH-1:0] mar_q;
  logic [WIDTH-1:0] mdr_q;
  logic [2:0]       nzp_q;
  logic [2:0]       nzp_d;
  logic             ben_q;
  logic [WIDTH-1:0] regs_q [8];

  logic [WIDTH-1:0] bus;
  logic [2:0]       sr1_idx;
  logic [2:0]       dr_idx;
  logic [WIDTH-1:0] sr1_val;
  logic [WIDTH-1:0] alu_b;
  logic [WIDTH-1:0] alu_out;
  logic [WIDTH-1:0] addr_base;
  logic [WIDTH-1:0] addr_off;
  logic [WIDTH-1:0] addr_sum;
  logic [WIDTH-1:0] pc_inc;
  logic             rd_complete;
  logic             mdr_ld_ok;

  // Register-file read ports, ALU and address adder
  always_comb begin
    sr1_idx = sr1mux ? ir_q[11:9] : ir_q[8:6];
    dr_idx  = drmux ? 3'd7 : ir_q[11:9];
    sr1_val = regs_q[sr1_idx];
    alu_b   = ir_q[5] ? {{(WIDTH-5){ir_q[4]}}, ir_q[4:0]} : regs_q[ir_q[2:0]];
    case (aluk)
      2'b00:   alu_out = sr1_val + alu_b;
      2'b01:   alu_out = sr1_val & alu_b;
      2'b10:   alu_out = ~sr1_val;
      default: alu_out = sr1_val;
    endcase
    addr_base = addr1mux ? sr1_val : pc_q;
    case (addr2mux)
      2'b00:   addr_off = '0;
      2'b01:   addr_off = {{(WIDTH-6){ir_q[5]}}, ir_q[5:0]};
      2'b10:   addr_off = {{(WIDTH-9){ir_q[8]}}, ir_q[8:0]};
      default: addr_off = {{(WIDTH-11){ir_q[10]}}, ir_q[10:0]};
    endcase
    addr_sum = addr_base + addr_off;
    pc_inc   = pc_q + WIDTH'(1);
  end

  // Bus driver selection; contention or no driver yields zero
  always_comb begin
    case (gate)
      4'b1000: bus = alu_out;
      4'b0100: bus = pc_q;
      4'b0010: bus = addr_sum;
      4'b0001: bus = mdr_q;
      default: bus = '0;
    endcase
    bus_err = |(gate & (gate - 4'd1));
  end

  // Next-state values for PC and condition codes, plus MDR load qualifiers
  always_comb begin
    case (pcmux)
      2'b00:   pc_d = pc_inc;
      2'b01:   pc_d = bus;
      default: pc_d = addr_sum;
    endcase
    if (bus[WIDTH-1])   nzp_d = 3'b100;
    else if (bus == '0) nzp_d = 3'b010;
    else                nzp_d = 3'b001;
    rd_complete = (state_q == MEM_WAIT) && !mem_wr_q && mem_ready;
    mdr_ld_ok   = ld[LD_MDR] && !((state_q == MEM_WAIT) && mem_wr_q);
  end

  // Architectural registers
  always_ff @(posedge Clk or negedge Reset_al) begin
    if (!Reset_al) begin
      pc_q  <= RESET_PC;
      ir_q  <= '0;
      mar_q <= '0;
      mdr_q <= '0;
      nzp_q <= 3'b010;
      ben_q <= 1'b0;
    end else begin
      if (ld[LD_PC] && (pcmux != 2'b11)) pc_q <= pc_d;
      if (ld[LD_IR]) ir_q <= bus;
      if (ld[LD_MAR] && (state_q == MEM_IDLE)) mar_q <= bus;
      if (rd_complete)    mdr_q <= mem_rdata;
      else if (mdr_ld_ok) mdr_q <= bus;
      if (ld[LD_CC])  nzp_q <= nzp_d;
      if (ld[LD_BEN]) ben_q <= |(ir_q[11:9] & nzp_q);
    end
  end

  // General-purpose register file write port
  always_ff @(posedge Clk or negedge Reset_al) begin
    if (!Reset_al) begin
      for (int unsigned i = 0; i < 8; i++) regs_q[i] <= '0;
    end else if (ld[LD_REG]) begin
      regs_q[dr_idx] <= bus;
    end
  end

  // Memory handshake FSM with registered outputs
  always_ff @(posedge Clk or negedge Reset_al) begin
    if (!Reset_al) begin
      state_q    <= MEM_IDLE;
      cnt_q      <= '0;
      mem_wr_q   <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_done_q <= 1'b0;
      mem_err_q  <= 1'b0;
    end else begin
      mem_done_q <= 1'b0;
      case (state_q)
        MEM_IDLE: begin
          if (mem_start) begin
            state_q   <= MEM_WAIT;
            mem_wr_q  <= mem_we;
            mem_err_q <= 1'b0;
            cnt_q     <= '0;
            mem_req_q <= 1'b1;
          end
        end
        MEM_WAIT: begin
          if (mem_ready) begin
            state_q    <= MEM_DONE;
            mem_req_q  <= 1'b0;
            mem_done_q <= 1'b1;
          end else if (cnt_q == TO_LAST) begin
            state_q    <= MEM_DONE;
            mem_req_q  <= 1'b0;
            mem_done_q <= 1'b1;
            mem_err_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: state_q <= MEM_IDLE;
      endcase
    end
  end

  assign mem_req  = mem_req_q;
  assign mem_wr   = mem_wr_q;
  assign mem_busy = (state_q != MEM_IDLE);
  assign mem_done = mem_done_q;
  assign mem_err  = mem_err_q;
  assign IR       = ir_q;
  assign PC       = pc_q;
  assign MAR      = mar_q;
  assign MDR      = mdr_q;
  assign nzp      = nzp_q;
  assign BEN      = ben_q;

endmodule

// File: tb/tb_param_datapath.sv
// Self-checking bench for param_datapath: directed scenarios plus a
// randomized run compared against an architectural reference model.
module tb_param_datapath;

  logic        Clk = 1'b0;
  logic        Reset_al;
  logic [6:0]  ld;
  logic [3:0]  gate;
  logic [1:0]  pcmux;
  logic        addr1mux;
  logic [1:0]  addr2mux;
  logic [1:0]  aluk;
  logic        sr1mux;
  logic        drmux;
  logic        mem_start;
  logic        mem_we;
  logic [15:0] mem_rdata;
  logic        mem_ready;
  logic        mem_req, mem_wr, mem_busy, mem_done, mem_err;
  logic [15:0] IR, PC, MAR, MDR;
  logic [2:0]  nzp;
  logic        BEN;
  logic        bus_err;

  int checks = 0;
  int errors = 0;

  param_datapath #(
    .WIDTH(16),
    .RESET_PC(16'h3000),
    .MEM_TIMEOUT(4)
  ) dut (
    .Clk(Clk), .Reset_al(Reset_al), .ld(ld), .gate(gate), .pcmux(pcmux),
    .addr1mux(addr1mux), .addr2mux(addr2mux), .aluk(aluk), .sr1mux(sr1mux),
    .drmux(drmux), .mem_start(mem_start), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .mem_req(mem_req),
    .mem_wr(mem_wr), .mem_busy(mem_busy), .mem_done(mem_done),
    .mem_err(mem_err), .IR(IR), .PC(PC), .MAR(MAR), .MDR(MDR), .nzp(nzp),
    .BEN(BEN), .bus_err(bus_err)
  );

  always #5 Clk = ~Clk;

  // Reference model state
  logic [15:0] m_pc, m_ir, m_mar, m_mdr;
  logic [15:0] m_r [8];
  logic [2:0]  m_nzp;
  logic        m_ben;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_inputs();
    ld = '0; gate = '0; pcmux = 2'b11; addr1mux = 1'b0; addr2mux = 2'b00;
    aluk = 2'b00; sr1mux = 1'b0; drmux = 1'b0; mem_start = 1'b0;
    mem_we = 1'b0; mem_rdata = '0; mem_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    Reset_al = 1'b0;
    tick();
    tick();
    Reset_al = 1'b1;
    tick();
  endtask

  // Places a value in MDR through a one-cycle-latency memory read
  task automatic mem_inject(input logic [15:0] data);
    ld = '0; gate = '0;
    mem_start = 1'b1; mem_we = 1'b0;
    tick();
    mem_start = 1'b0; mem_ready = 1'b1; mem_rdata = data;
    tick();
    mem_ready = 1'b0;
    checks++;
    if (MDR !== data) begin
      errors++; $display("FAIL inject_mdr: got %h exp %h", MDR, data);
    end
    tick();
  endtask

  function automatic logic [15:0] sx(input logic [15:0] v, input int unsigned n);
    logic signed [15:0] t;
    t = v << (16 - n);
    return t >>> (16 - n);
  endfunction

  function automatic logic [15:0] model_bus();
    logic [15:0] a, b, alu, base, off;
    a = sr1mux ? m_r[m_ir[11:9]] : m_r[m_ir[8:6]];
    b = m_ir[5] ? sx(m_ir, 5) : m_r[m_ir[2:0]];
    case (aluk)
      2'd0: alu = a + b;
      2'd1: alu = a & b;
      2'd2: alu = ~a;
      default: alu = a;
    endcase
    base = addr1mux ? a : m_pc;
    case (addr2mux)
      2'd0: off = 16'd0;
      2'd1: off = sx(m_ir, 6);
      2'd2: off = sx(m_ir, 9);
      default: off = sx(m_ir, 11);
    endcase
    if ($countones(gate) != 1) return 16'd0;
    if (gate[3]) return alu;
    if (gate[2]) return m_pc;
    if (gate[1]) return base + off;
    return m_mdr;
  endfunction

  task automatic model_step(input logic [15:0] bus);
    logic [15:0] base, off, a;
    logic [2:0]  old_nzp;
    a = sr1mux ? m_r[m_ir[11:9]] : m_r[m_ir[8:6]];
    base = addr1mux ? a : m_pc;
    case (addr2mux)
      2'd0: off = 16'd0;
      2'd1: off = sx(m_ir, 6);
      2'd2: off = sx(m_ir, 9);
      default: off = sx(m_ir, 11);
    endcase
    old_nzp = m_nzp;
    if (ld[0]) m_ben = |(m_ir[11:9] & old_nzp);
    if (ld[1]) m_nzp = ($signed(bus) < 0) ? 3'b100 : (bus == 16'd0) ? 3'b010 : 3'b001;
    if (ld[2]) m_r[drmux ? 3'd7 : m_ir[11:9]] = bus;
    if (ld[3]) m_mdr = bus;
    if (ld[4]) m_mar = bus;
    if (ld[6]) begin
      case (pcmux)
        2'd0: m_pc = m_pc + 16'd1;
        2'd1: m_pc = bus;
        2'd2: m_pc = base + off;
        default: m_pc = m_pc;
      endcase
    end
    if (ld[5]) m_ir = bus;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (PC !== 16'h3000 || IR !== 16'h0 || MAR !== 16'h0 || MDR !== 16'h0) begin
      errors++; $display("FAIL reset_regs: PC=%h IR=%h MAR=%h MDR=%h exp 3000/0/0/0", PC, IR, MAR, MDR);
    end
    checks++;
    if (nzp !== 3'b010 || BEN !== 1'b0) begin
      errors++; $display("FAIL reset_cc: nzp=%b BEN=%b exp 010/0", nzp, BEN);
    end
    checks++;
    if ({mem_req, mem_wr, mem_busy, mem_done, mem_err} !== 5'b0) begin
      errors++; $display("FAIL reset_mem: got %b exp 00000", {mem_req, mem_wr, mem_busy, mem_done, mem_err});
    end
  endtask

  task automatic test_pc();
    ld = 7'b1000000; pcmux = 2'b00;
    repeat (3) tick();
    checks++;
    if (PC !== 16'h3003) begin errors++; $display("FAIL pc_inc3: got %h exp 3003", PC); end
    pcmux = 2'b11;
    tick();
    checks++;
    if (PC !== 16'h3003) begin errors++; $display("FAIL pc_hold: got %h exp 3003", PC); end
    gate = 4'b1000; aluk = 2'b10; pcmux = 2'b01;
    tick();
    checks++;
    if (PC !== 16'hFFFF) begin errors++; $display("FAIL pc_bus: got %h exp ffff", PC); end
    gate = 4'b0000; pcmux = 2'b00;
    tick();
    checks++;
    if (PC !== 16'h0000) begin errors++; $display("FAIL pc_wrap: got %h exp 0000", PC); end
    idle_inputs();
  endtask

  task automatic test_alu();
    mem_inject(16'h7FFF);
    gate = 4'b0001; ld = 7'b0000100; drmux = 1'b0;
    tick();
    mem_inject(16'h1021);
    gate = 4'b0001; ld = 7'b0100000;
    tick();
    checks++;
    if (IR !== 16'h1021) begin errors++; $display("FAIL ir_load: got %h exp 1021", IR); end
    gate = 4'b1000; aluk = 2'b00; sr1mux = 1'b0; ld = 7'b0000110;
    tick();
    checks++;
    if (nzp !== 3'b100) begin errors++; $display("FAIL add_nzp: got %b exp 100", nzp); end
    aluk = 2'b11; ld = 7'b0010000;
    tick();
    checks++;
    if (MAR !== 16'h8000) begin errors++; $display("FAIL add_wrap_r0: got %h exp 8000", MAR); end
    mem_inject(16'h0E00);
    gate = 4'b0001; ld = 7'b0100000;
    tick();
    gate = 4'b0000; ld = 7'b0000001;
    tick();
    checks++;
    if (BEN !== 1'b1) begin errors++; $display("FAIL ben: got %b exp 1", BEN); end
    idle_inputs();
  endtask

  task automatic test_mem_read();
    mem_inject(16'h0040);
    gate = 4'b0001; ld = 7'b0010000;
    tick();
    checks++;
    if (MAR !== 16'h0040) begin errors++; $display("FAIL mar_load: got %h exp 0040", MAR); end
    gate = 4'b0000; ld = '0;
    mem_start = 1'b1; mem_we = 1'b0;
    tick();
    checks++;
    if (mem_req !== 1'b1 || mem_busy !== 1'b1 || mem_wr !== 1'b0) begin
      errors++; $display("FAIL rd_start: req=%b busy=%b wr=%b exp 1/1/0", mem_req, mem_busy, mem_wr);
    end
    mem_start = 1'b1; mem_we = 1'b1;
    gate = 4'b1000; aluk = 2'b10; ld = 7'b0010000;
    tick();
    checks++;
    if (mem_wr !== 1'b0 || MAR !== 16'h0040 || mem_done !== 1'b0) begin
      errors++; $display("FAIL busy_ignore: wr=%b MAR=%h done=%b exp 0/0040/0", mem_wr, MAR, mem_done);
    end
    mem_start = 1'b0; mem_we = 1'b0; ld = '0; gate = '0;
    tick();
    mem_ready = 1'b1; mem_rdata = 16'hBEEF; ld = 7'b0001000; gate = 4'b0000;
    tick();
    checks++;
    if (mem_done !== 1'b1 || MDR !== 16'hBEEF || mem_err !== 1'b0 || mem_req !== 1'b0) begin
      errors++; $display("FAIL rd_done: done=%b MDR=%h err=%b req=%b exp 1/beef/0/0", mem_done, MDR, mem_err, mem_req);
    end
    mem_ready = 1'b0; ld = '0;
    tick();
    checks++;
    if (mem_done !== 1'b0 || mem_busy !== 1'b0) begin
      errors++; $display("FAIL rd_pulse: done=%b busy=%b exp 0/0", mem_done, mem_busy);
    end
    idle_inputs();
  endtask

  task automatic test_timeout();
    mem_start = 1'b1; mem_we = 1'b1;
    tick();
    mem_start = 1'b0; mem_we = 1'b0; ld = 7'b0001000; gate = 4'b0000;
    checks++;
    if (mem_wr !== 1'b1) begin errors++; $display("FAIL wr_latch: got %b exp 1", mem_wr); end
    for (int c = 1; c <= 4; c++) begin
      checks++;
      if (mem_done !== 1'b0 || mem_req !== 1'b1) begin
        errors++; $display("FAIL to_wait c%0d: done=%b req=%b exp 0/1", c, mem_done, mem_req);
      end
      tick();
    end
    checks++;
    if (mem_done !== 1'b1 || mem_err !== 1'b1 || MDR !== 16'hBEEF || mem_req !== 1'b0) begin
      errors++; $display("FAIL to_done: done=%b err=%b MDR=%h req=%b exp 1/1/beef/0", mem_done, mem_err, MDR, mem_req);
    end
    ld = '0;
    tick();
    checks++;
    if (mem_done !== 1'b0 || mem_err !== 1'b1 || mem_busy !== 1'b0) begin
      errors++; $display("FAIL to_sticky: done=%b err=%b busy=%b exp 0/1/0", mem_done, mem_err, mem_busy);
    end
    mem_start = 1'b1;
    tick();
    mem_start = 1'b0;
    checks++;
    if (mem_err !== 1'b0) begin errors++; $display("FAIL err_clear: got %b exp 0", mem_err); end
    mem_ready = 1'b1; mem_rdata = 16'h1234;
    tick();
    mem_ready = 1'b0;
    tick();
    idle_inputs();
  endtask

  task automatic test_bus_err();
    gate = 4'b1010;
    #1;
    checks++;
    if (bus_err !== 1'b1) begin errors++; $display("FAIL bus_err_multi: got %b exp 1", bus_err); end
    ld = 7'b0100000;
    tick();
    checks++;
    if (IR !== 16'h0000) begin errors++; $display("FAIL bus_err_zero: got %h exp 0000", IR); end
    gate = 4'b0100; ld = '0;
    #1;
    checks++;
    if (bus_err !== 1'b0) begin errors++; $display("FAIL bus_err_onehot: got %b exp 0", bus_err); end
    gate = 4'b0000; ld = 7'b0000010;
    tick();
    checks++;
    if (nzp !== 3'b010) begin errors++; $display("FAIL cc_zero_bus: got %b exp 010", nzp); end
    idle_inputs();
  endtask

  task automatic test_reset_wait();
    mem_start = 1'b1; mem_we = 1'b0;
    tick();
    mem_start = 1'b0;
    #2;
    Reset_al = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0 || mem_busy !== 1'b0) begin
      errors++; $display("FAIL async_abort: req=%b busy=%b exp 0/0", mem_req, mem_busy);
    end
    tick();
    Reset_al = 1'b1;
    tick();
    mem_start = 1'b1;
    tick();
    mem_start = 1'b0; mem_ready = 1'b1; mem_rdata = 16'h5A5A;
    tick();
    checks++;
    if (mem_done !== 1'b1 || MDR !== 16'h5A5A || mem_err !== 1'b0) begin
      errors++; $display("FAIL after_reset_txn: done=%b MDR=%h err=%b exp 1/5a5a/0", mem_done, MDR, mem_err);
    end
    mem_ready = 1'b0;
    tick();
    idle_inputs();
  endtask

  task automatic test_mem_random();
    logic [15:0] exp_mdr;
    logic [15:0] data;
    logic        we;
    int          k;
    exp_mdr = MDR === 16'h5A5A ? 16'h5A5A : 16'h5A5A;
    for (int t = 0; t < 10; t++) begin
      we = 1'($urandom_range(0, 1));
      k = $urandom_range(1, 4);
      data = 16'($urandom);
      mem_start = 1'b1; mem_we = we;
      tick();
      mem_start = 1'b0;
      for (int c = 1; c < k; c++) begin
        checks++;
        if (mem_done !== 1'b0 || mem_req !== 1'b1 || mem_wr !== we) begin
          errors++; $display("FAIL rnd_wait t%0d c%0d: done=%b req=%b wr=%b exp 0/1/%b", t, c, mem_done, mem_req, mem_wr, we);
        end
        tick();
      end
      mem_ready = 1'b1; mem_rdata = data;
      tick();
      mem_ready = 1'b0;
      if (!we) exp_mdr = data;
      checks++;
      if (mem_done !== 1'b1 || mem_err !== 1'b0 || MDR !== exp_mdr) begin
        errors++; $display("FAIL rnd_done t%0d k%0d: done=%b err=%b MDR=%h exp 1/0/%h", t, k, mem_done, mem_err, MDR, exp_mdr);
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_random_datapath();
    logic [15:0] eb;
    do_reset();
    m_pc = 16'h3000; m_ir = '0; m_mar = '0; m_mdr = '0;
    for (int i = 0; i < 8; i++) m_r[i] = '0;
    m_nzp = 3'b010; m_ben = 1'b0;
    for (int c = 0; c < 300; c++) begin
      ld = 7'($urandom);
      gate = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'(1 << $urandom_range(0, 3));
      pcmux = 2'($urandom); addr1mux = 1'($urandom); addr2mux = 2'($urandom);
      aluk = 2'($urandom); sr1mux = 1'($urandom); drmux = 1'($urandom);
      #1;
      checks++;
      if (bus_err !== ($countones(gate) > 1)) begin
        errors++; $display("FAIL rnd_bus_err c%0d: got %b gate=%b", c, bus_err, gate);
      end
      eb = model_bus();
      model_step(eb);
      tick();
      checks++;
      if (PC !== m_pc || IR !== m_ir || MAR !== m_mar || MDR !== m_mdr) begin
        errors++; $display("FAIL rnd_regs c%0d: PC=%h IR=%h MAR=%h MDR=%h exp %h %h %h %h", c, PC, IR, MAR, MDR, m_pc, m_ir, m_mar, m_mdr);
      end
      checks++;
      if (nzp !== m_nzp || BEN !== m_ben) begin
        errors++; $display("FAIL rnd_cc c%0d: nzp=%b BEN=%b exp %b %b", c, nzp, BEN, m_nzp, m_ben);
      end
    end
    idle_inputs();
  endtask

  initial begin
    Reset_al = 1'b1;
    idle_inputs();
    test_reset();
    test_pc();
    test_alu();
    test_mem_read();
    test_timeout();
    test_bus_err();
    test_reset_wait();
    test_mem_random();
    test_random_datapath();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
